// File: rtl/tech_ram_arb.sv
// Two-requester round-robin front end for a single-port tech_ram, with a hardware zero-fill after reset/clear.
// Request->RAM is combinational, read data returns one cycle after accept; responses have no backpressure.
module tech_ram_arb #(
   parameter  int BIT_WIDTH  = 128,
   parameter  int WORD_DEPTH = 64,
   localparam int AW         = $clog2(WORD_DEPTH)
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      clear_i,
   output logic                      init_done_o,
   input  logic [1:0]                req_valid_i,
   output logic [1:0]                req_ready_o,
   input  logic [1:0]                req_we_i,
   input  logic [1:0][AW-1:0]        req_addr_i,
   input  logic [1:0][BIT_WIDTH-1:0] req_dat_i,
   output logic [1:0]                rsp_valid_o,
   output logic [BIT_WIDTH-1:0]      rsp_dat_o,
   output logic                      ram_en_o,
   output logic                      ram_wen_o,
   output logic [AW-1:0]             ram_addr_o,
   output logic [BIT_WIDTH-1:0]      ram_dat_o,
   input  logic [BIT_WIDTH-1:0]      ram_dat_i
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(WORD_DEPTH - 1);

   state_t        state;
   logic [AW-1:0] fill_cnt;
   logic          rr_ptr;
   logic [1:0]    rsp_q;
   logic [1:0]    grant;
   logic [1:0]    accept;
   logic          sel;

   // Pointer only breaks ties; a lone requester always wins.
   always_comb begin
      grant = req_valid_i;
      if (&req_valid_i) begin
         grant = rr_ptr ? 2'b10 : 2'b01;
      end
      accept = ((state == ST_RUN) && !clear_i) ? grant : 2'b00;
      sel    = accept[1];
   end

   always_comb begin
      ram_en_o   = 1'b1;
      ram_wen_o  = 1'b1;
      ram_addr_o = '0;
      ram_dat_o  = '0;
      if (state == ST_INIT) begin
         ram_en_o   = 1'b0;
         ram_wen_o  = 1'b0;
         ram_addr_o = fill_cnt;
      end else if (|accept) begin
         ram_en_o   = 1'b0;
         ram_wen_o  = ~req_we_i[sel];
         ram_addr_o = req_addr_i[sel];
         ram_dat_o  = req_dat_i[sel];
      end
   end

   assign req_ready_o = accept;
   assign rsp_valid_o = rsp_q;
   assign rsp_dat_o   = ram_dat_i;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state       <= ST_INIT;
         fill_cnt    <= '0;
         rr_ptr      <= 1'b0;
         rsp_q       <= 2'b00;
         init_done_o <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               rsp_q    <= 2'b00;
               fill_cnt <= fill_cnt + AW'(1);
               if (fill_cnt == LAST_ADDR) begin
                  state       <= ST_RUN;
                  init_done_o <= 1'b1;
               end
            end
            ST_RUN: begin
               rsp_q <= accept & ~req_we_i;
               if (accept[0]) begin
                  rr_ptr <= 1'b1;
               end else if (accept[1]) begin
                  rr_ptr <= 1'b0;
               end
               // A response owed from last cycle still drains this cycle via rsp_q.
               if (clear_i) begin
                  state       <= ST_INIT;
                  fill_cnt    <= '0;
                  init_done_o <= 1'b0;
               end
            end
            default: begin
               state       <= ST_INIT;
               fill_cnt    <= '0;
               init_done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tech_ram_arb.sv
// Directed bench for tech_ram_arb with a behavioural tech_ram and a response scoreboard.
module tb_tech_ram_arb;
   localparam int W  = 128;
   localparam int D  = 64;
   localparam int AW = 6;

   logic               clk_i = 1'b0;
   logic               rst_n_i;
   logic               clear_i;
   logic               init_done_o;
   logic [1:0]         req_valid_i;
   logic [1:0]         req_ready_o;
   logic [1:0]         req_we_i;
   logic [1:0][AW-1:0] req_addr_i;
   logic [1:0][W-1:0]  req_dat_i;
   logic [1:0]         rsp_valid_o;
   logic [W-1:0]       rsp_dat_o;
   logic               ram_en_o;
   logic               ram_wen_o;
   logic [AW-1:0]      ram_addr_o;
   logic [W-1:0]       ram_dat_o;
   logic [W-1:0]       ram_dat_i;

   tech_ram_arb #(.BIT_WIDTH(W), .WORD_DEPTH(D)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(clear_i), .init_done_o(init_done_o),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_dat_i(req_dat_i), .rsp_valid_o(rsp_valid_o),
      .rsp_dat_o(rsp_dat_o), .ram_en_o(ram_en_o), .ram_wen_o(ram_wen_o),
      .ram_addr_o(ram_addr_o), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural single-port RAM: active-low enable, registered read data.
   logic [W-1:0] mem [D];
   always @(posedge clk_i) begin
      if (!ram_en_o) begin
         if (!ram_wen_o) mem[ram_addr_o] <= ram_dat_o;
         else            ram_dat_i <= mem[ram_addr_o];
      end
   end

   typedef struct {
      logic         id;
      logic [W-1:0] dat;
   } sb_t;

   sb_t          sb[$];
   logic [W-1:0] ref_mem [D];
   int           checks   = 0;
   int           failures = 0;

   localparam logic [W-1:0] PAT_A5 = {4{32'hA5A5_A5A5}};
   localparam logic [W-1:0] PAT_1  = {4{32'h1111_0001}};
   localparam logic [W-1:0] PAT_2  = {4{32'h2222_0002}};

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_rsp();
      sb_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rsp_valid", {126'd0, rsp_valid_o}, e.id ? 128'd2 : 128'd1);
         chk("rsp_dat", rsp_dat_o, e.dat);
      end else begin
         chk("rsp_idle", {126'd0, rsp_valid_o}, 128'd0);
      end
   endtask

   // One RUN cycle: drive, check at negedge, update the reference model from the expected grant.
   task automatic cyc(input logic [1:0] v, input logic [1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic clr, input logic [1:0] exp_rdy);
      int s;
      req_valid_i   = v;
      req_we_i      = we;
      req_addr_i[0] = a0;
      req_addr_i[1] = a1;
      req_dat_i[0]  = d0;
      req_dat_i[1]  = d1;
      clear_i       = clr;
      @(negedge clk_i);
      check_rsp();
      chk("init_done", {127'd0, init_done_o}, 128'd1);
      chk("ready", {126'd0, req_ready_o}, {126'd0, exp_rdy});
      if (exp_rdy != 2'b00) begin
         s = exp_rdy[1] ? 1 : 0;
         chk("ram_en", {127'd0, ram_en_o}, 128'd0);
         chk("ram_wen", {127'd0, ram_wen_o}, {127'd0, ~we[s]});
         chk("ram_addr", {122'd0, ram_addr_o}, {122'd0, req_addr_i[s]});
         if (we[s]) begin
            chk("ram_dat", ram_dat_o, req_dat_i[s]);
            ref_mem[req_addr_i[s]] = req_dat_i[s];
         end else begin
            sb.push_back('{id: s[0], dat: ref_mem[req_addr_i[s]]});
         end
      end else begin
         chk("ram_idle", {127'd0, ram_en_o}, 128'd1);
      end
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
   endtask

   // Checks n fill cycles from address 0; requests are held valid to prove they are never accepted.
   task automatic init_seq(input int n, input int clr_at);
      for (int k = 0; k < D; k++) ref_mem[k] = '0;
      req_valid_i = 2'b11;
      req_we_i    = 2'b00;
      for (int i = 0; i < n; i++) begin
         clear_i = (i == clr_at);
         @(negedge clk_i);
         check_rsp();
         chk("init_en", {127'd0, ram_en_o}, 128'd0);
         chk("init_wen", {127'd0, ram_wen_o}, 128'd0);
         chk("init_addr", {122'd0, ram_addr_o}, W'(i));
         chk("init_dat", ram_dat_o, 128'd0);
         chk("init_ready", {126'd0, req_ready_o}, 128'd0);
         chk("init_done_lo", {127'd0, init_done_o}, 128'd0);
         @(posedge clk_i);
         #1;
      end
      clear_i     = 1'b0;
      req_valid_i = 2'b00;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n_i     = 1'b0;
      clear_i     = 1'b0;
      req_valid_i = 2'b00;
      req_we_i    = 2'b00;
      req_addr_i  = '0;
      req_dat_i   = '0;

      // Reset values
      repeat (3) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_rsp();
      chk("rst_ready", {126'd0, req_ready_o}, 128'd0);
      chk("rst_done", {127'd0, init_done_o}, 128'd0);
      chk("rst_en", {127'd0, ram_en_o}, 128'd0);
      chk("rst_wen", {127'd0, ram_wen_o}, 128'd0);
      chk("rst_addr", {122'd0, ram_addr_o}, 128'd0);
      chk("rst_dat", ram_dat_o, 128'd0);
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;

      // Reset fill, with a clear pulse that must be ignored mid-fill
      init_seq(D, 10);

      // Read of a filled word
      cyc(2'b01, 2'b00, 6'd17, 6'd0, '0, '0, 1'b0, 2'b01);
      cyc(2'b00, 2'b00, 6'd0, 6'd0, '0, '0, 1'b0, 2'b00);

      // Single requester write then read
      cyc(2'b01, 2'b01, 6'd5, 6'd0, PAT_A5, '0, 1'b0, 2'b01);
      cyc(2'b01, 2'b00, 6'd5, 6'd0, '0, '0, 1'b0, 2'b01);
      cyc(2'b00, 2'b00, 6'd0, 6'd0, '0, '0, 1'b0, 2'b00);

      // Lone requesters win regardless of pointer; req1-only grant leaves pointer at 0
      cyc(2'b01, 2'b01, 6'd1, 6'd0, PAT_1, '0, 1'b0, 2'b01);
      cyc(2'b10, 2'b10, 6'd0, 6'd2, '0, PAT_2, 1'b0, 2'b10);

      // Contention: continuous reads alternate starting with req0
      for (int i = 0; i < 6; i++) begin
         cyc(2'b11, 2'b00, 6'd1, 6'd2, '0, '0, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      cyc(2'b00, 2'b00, 6'd0, 6'd0, '0, '0, 1'b0, 2'b00);

      // Clear mid-traffic: owed response drains during the clear cycle
      cyc(2'b01, 2'b00, 6'd5, 6'd0, '0, '0, 1'b0, 2'b01);
      cyc(2'b01, 2'b00, 6'd1, 6'd0, '0, '0, 1'b1, 2'b00);
      init_seq(D, -1);
      cyc(2'b01, 2'b00, 6'd5, 6'd0, '0, '0, 1'b0, 2'b01);
      cyc(2'b10, 2'b00, 6'd0, 6'd2, '0, '0, 1'b0, 2'b10);
      cyc(2'b00, 2'b00, 6'd0, 6'd0, '0, '0, 1'b0, 2'b00);

      // Reset mid-INIT at counter 30
      cyc(2'b01, 2'b01, 6'd9, 6'd0, PAT_A5, '0, 1'b1, 2'b00);
      init_seq(30, -1);
      rst_n_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      init_seq(D, -1);
      cyc(2'b01, 2'b00, 6'd63, 6'd0, '0, '0, 1'b0, 2'b01);
      cyc(2'b00, 2'b00, 6'd0, 6'd0, '0, '0, 1'b0, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
